// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and widths for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int unsigned c_cnt_w  = 32;
    localparam int unsigned c_wait_w = 8;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_rr;
        logic rr_ex;
        logic ex_mem;
    } lock_t;

    typedef struct packed {
        logic if_id;
        logic id_rr;
        logic rr_ex;
        logic mem_wb;
    } flush_t;

    // Saturating increment for the data-memory wait counter.
    function automatic logic [c_wait_w-1:0] wait_inc(input logic [c_wait_w-1:0] v);
        return (v == {c_wait_w{1'b1}}) ? v : v + c_wait_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Hazard inputs from the pipeline and control outputs back to it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0]         rr_rs1_i;
    logic [4:0]         rr_rs2_i;
    logic               rr_use_rs1_i;
    logic               rr_use_rs2_i;
    logic [4:0]         ex_rd_i;
    logic               ex_memread_i;
    logic               ex_redirect_i;
    logic               dmem_req_i;
    logic               dmem_ready_i;

    logic               pc_lock_o;
    logic               if_id_lock_o;
    logic               id_rr_lock_o;
    logic               rr_ex_lock_o;
    logic               ex_mem_lock_o;
    logic               if_id_flush_o;
    logic               id_rr_flush_o;
    logic               rr_ex_flush_o;
    logic               mem_wb_flush_o;
    logic               pc_sel_o;
    logic               mem_err_o;
    logic [c_cnt_w-1:0] stall_cnt_o;
    logic [c_cnt_w-1:0] flush_cnt_o;

    // Pipeline side: supplies hazard information, consumes control.
    modport master (
        output rr_rs1_i, rr_rs2_i, rr_use_rs1_i, rr_use_rs2_i,
               ex_rd_i, ex_memread_i, ex_redirect_i, dmem_req_i, dmem_ready_i,
        input  pc_lock_o, if_id_lock_o, id_rr_lock_o, rr_ex_lock_o, ex_mem_lock_o,
               if_id_flush_o, id_rr_flush_o, rr_ex_flush_o, mem_wb_flush_o,
               pc_sel_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  rr_rs1_i, rr_rs2_i, rr_use_rs1_i, rr_use_rs2_i,
               ex_rd_i, ex_memread_i, ex_redirect_i, dmem_req_i, dmem_ready_i,
        output pc_lock_o, if_id_lock_o, id_rr_lock_o, rr_ex_lock_o, ex_mem_lock_o,
               if_id_flush_o, id_rr_flush_o, rr_ex_flush_o, mem_wb_flush_o,
               pc_sel_o, mem_err_o, stall_cnt_o, flush_cnt_o
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter with enable and synchronous clear, holds at all-ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_count <= '0;
        end else if (en_i && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush/redirect control for a 5-stage pipeline with a
//                data-memory wait state and sticky timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [c_wait_w-1:0] c_timeout = c_wait_w'(MEM_TIMEOUT);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_nxt;
    logic                r_mem_err;

    logic                w_mem_stall;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_load_use;
    lock_t               w_lock;
    flush_t              w_flush;
    logic                w_pc_sel;
    logic [c_cnt_w-1:0]  w_stall_cnt;
    logic [c_cnt_w-1:0]  w_flush_cnt;

    // A request that drops while waiting behaves exactly like a ready.
    assign w_mem_stall = hz.dmem_req_i & ~hz.dmem_ready_i;

    assign w_rs1_hit  = hz.rr_use_rs1_i & (hz.rr_rs1_i == hz.ex_rd_i);
    assign w_rs2_hit  = hz.rr_use_rs2_i & (hz.rr_rs2_i == hz.ex_rd_i);
    assign w_load_use = hz.ex_memread_i & (hz.ex_rd_i != 5'd0) & (w_rs1_hit | w_rs2_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt >= c_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = c_wait_w'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_wait_nxt = wait_inc(r_wait_cnt);
                end else begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Reset forces bubbles everywhere; otherwise mem stall > redirect > load-use.
    always_comb begin
        w_lock   = '0;
        w_flush  = '0;
        w_pc_sel = 1'b0;
        if (rst_i) begin
            w_flush = '1;
        end else if (w_mem_stall) begin
            w_lock         = '1;
            w_flush.mem_wb = 1'b1;
        end else if (hz.ex_redirect_i) begin
            w_pc_sel      = 1'b1;
            w_flush.if_id = 1'b1;
            w_flush.id_rr = 1'b1;
            w_flush.rr_ex = 1'b1;
        end else if (w_load_use) begin
            w_lock.pc     = 1'b1;
            w_lock.if_id  = 1'b1;
            w_lock.id_rr  = 1'b1;
            w_flush.rr_ex = 1'b1;
        end
    end

    sat_counter #(
        .WIDTH (c_cnt_w)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .en_i    (|w_lock),
        .count_o (w_stall_cnt)
    );

    sat_counter #(
        .WIDTH (c_cnt_w)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .en_i    (w_pc_sel),
        .count_o (w_flush_cnt)
    );

    assign hz.pc_lock_o      = w_lock.pc;
    assign hz.if_id_lock_o   = w_lock.if_id;
    assign hz.id_rr_lock_o   = w_lock.id_rr;
    assign hz.rr_ex_lock_o   = w_lock.rr_ex;
    assign hz.ex_mem_lock_o  = w_lock.ex_mem;
    assign hz.if_id_flush_o  = w_flush.if_id;
    assign hz.id_rr_flush_o  = w_flush.id_rr;
    assign hz.rr_ex_flush_o  = w_flush.rr_ex;
    assign hz.mem_wb_flush_o = w_flush.mem_wb;
    assign hz.pc_sel_o       = w_pc_sel;
    assign hz.mem_err_o      = r_mem_err;
    assign hz.stall_cnt_o    = w_stall_cnt;
    assign hz.flush_cnt_o    = w_flush_cnt;

endmodule
`default_nettype wire
